ychip_run_ctrl: RTL
===================

// Module: ychip_run_ctrl
// PURPOSE
//  Run controller sitting directly upstream of yChip; drives its INT and entryPoint inputs.
//  Parks the core on a self-loop halt instruction while idle, launches a program at a
//  requested word-aligned address on start, and watches the fetched instruction word.
//  Stops the run on a halt instruction or on a cycle budget; reports status and run cycles.
// PARAMETERS
//  HALT_INS    32'h0000006F  halt encoding (jal x0,0); matched against ins every RUN cycle
//  PARK_ADDR   32'h00000000  address driven on entryPoint when not running; must hold HALT_INS
//  MAX_CYCLES  1024          RUN-cycle budget before timeout; legal range 1..2**CNT_W-1
//  CNT_W       16            width of cycle counter
// PORTS
//  clk         in   1      single clock, rising edge; shared with yChip
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      launch request; sampled only in IDLE/DONE/TOUT
//  abort       in   1      cancel request; effective in ARM/RUN
//  entryIn     in   32     program start address, latched on accepted start
//  ins         in   32     instruction word currently fetched by yChip
//  INT         out  1      to yChip INT; 1 = force PC <= entryPoint at next edge
//  entryPoint  out  32     to yChip entryPoint (registered)
//  busy        out  1      1 in ARM or RUN
//  done        out  1      sticky: run ended on HALT_INS
//  timeout     out  1      sticky: run ended on budget exhaustion
//  startErr    out  1      one-cycle pulse: start rejected, entryIn[1:0] != 2'b00
//  cycles      out  CNT_W  number of RUN cycles of the current/last run
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, INT=1, entryPoint=PARK_ADDR, busy=0, done=0,
//   timeout=0, startErr=0, cycles=0. Release takes effect at next clk edge; no other wait.
//  States: IDLE, ARM, RUN, DONE, TOUT (state is a register). INT = (state != RUN),
//   busy = (state==ARM | state==RUN); both are decoded from state only, so they are glitch-free.
//  IDLE/DONE/TOUT, start=1, entryIn[1:0]==0: next state=ARM; entryPoint<=entryIn;
//   cycles<=0; done<=0; timeout<=0.
//  Same states, start=1, entryIn misaligned: state is unchanged; startErr=1 for one cycle;
//   flags and cycles are unchanged.
//  ARM: one cycle with INT=1, so yChip loads PC<=entryPoint at this edge. Next state=RUN.
//  RUN: INT=0; every edge cycles<=cycles+1 (saturates at all-ones). Priority at each edge:
//   1) abort=1 -> IDLE, entryPoint<=PARK_ADDR, cycles is not incremented.
//   2) ins==HALT_INS -> DONE, done<=1, entryPoint<=PARK_ADDR.
//   3) cycles+1==MAX_CYCLES -> TOUT, timeout<=1, entryPoint<=PARK_ADDR.
//   4) otherwise stay in RUN.
//  The halt cycle is counted: a program of N non-halt instructions followed by the halt
//   ends with cycles=N+1. The first ins seen in RUN is mem[entryIn].
//  ARM with abort=1 -> IDLE, entryPoint<=PARK_ADDR.
//  Abort and start in any other state: abort is ignored; start in ARM/RUN is ignored.
//  DONE/TOUT: INT=1 and the core spins on PARK_ADDR. done, timeout and cycles hold until
//   the next accepted start.
//  Halt wins over timeout on the same edge. Only one of done/timeout is ever 1.
//  Reset asserted mid-run returns to the reset values immediately. The controller does not
//   reset yChip register or memory contents.
//  Cycle-level launch timeline: start at edge E0 -> ARM; E1 -> PC=entry, RUN.
//   First instruction executes in cycle E1..E2.
// TESTING
//  1 Reset, idle 5 cycles -> INT=1, entryPoint=0x0, busy=0, cycles=0; core ins==HALT_INS.
//  2 Program at 0x40: 3 addi, then halt; start with entryIn=0x40 -> ARM for 1 cycle;
//    RUN for 4 cycles; done=1, cycles=4, entryPoint=0x0, INT=1.
//  3 MAX_CYCLES=8, program is a tight beq loop that never halts -> timeout=1 after 8 RUN
//    cycles, cycles=8, done=0.
//  4 start with entryIn=0x42 -> startErr pulse of 1 cycle, state stays IDLE, entryPoint=0x0.
//  5 abort in the 3rd RUN cycle -> IDLE next edge, cycles=2, done=timeout=0, INT=1.
//  6 rst_n=0 mid-RUN, then restart from DONE with a new entryIn=0x80 -> flags clear,
//    cycles restarts from 0, first ins seen = mem[0x80].

Source files
------------

// File: rtl/ychip_run_ctrl_if.sv
// ychip_run_ctrl_if: bundle between the yChip run controller and its environment.
//   start, abort, entryIn : launch/cancel requests and program start address
//   ins                   : instruction word currently fetched by yChip
//   INT, entryPoint       : drive yChip INT / entryPoint inputs
//   busy, done, timeout   : run status (done/timeout are sticky)
//   startErr              : one-cycle pulse on a rejected (misaligned) start
//   cycles                : RUN-cycle count of the current/last run
// Modports: slave = controller side, master = environment side.
interface ychip_run_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [31:0]      entryIn;
  logic [31:0]      ins;
  logic             INT;
  logic [31:0]      entryPoint;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             startErr;
  logic [CNT_W-1:0] cycles;

  modport slave (
    input  start, abort, entryIn, ins,
    output INT, entryPoint, busy, done, timeout, startErr, cycles
  );

  modport master (
    output start, abort, entryIn, ins,
    input  INT, entryPoint, busy, done, timeout, startErr, cycles
  );
endinterface

// File: rtl/ychip_run_ctrl.sv
// ychip_run_ctrl: run controller directly upstream of yChip.
// Parks the core on a self-loop halt instruction while idle, launches a program at a
// word-aligned address on start, and ends the run on a halt instruction, an abort or
// when the RUN-cycle budget is exhausted.
// Ports:
//   clk   : rising-edge clock shared with yChip
//   rst_n : asynchronous active-low reset
//   bus   : ychip_run_ctrl_if.slave (requests, fetched ins, yChip drive, status)
module ychip_run_ctrl #(
  parameter logic [31:0] HALT_INS   = 32'h0000_006F,
  parameter logic [31:0] PARK_ADDR  = 32'h0000_0000,
  parameter int unsigned MAX_CYCLES = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ychip_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_CYCLES);

  state_t           state_q;
  logic [31:0]      entry_q;
  logic             done_q;
  logic             tout_q;
  logic             err_q;
  logic [CNT_W-1:0] cycles_q;

  // Unsaturated increment is used for the budget compare; the stored count saturates.
  logic [CNT_W:0]   cycles_plus;
  logic [CNT_W-1:0] cycles_sat;

  always_comb begin
    cycles_plus = {1'b0, cycles_q} + 1'b1;
    cycles_sat  = cycles_plus[CNT_W] ? '1 : cycles_plus[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      entry_q  <= PARK_ADDR;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_TOUT: begin
          if (bus.start) begin
            if (bus.entryIn[1:0] == 2'b00) begin
              state_q  <= S_ARM;
              entry_q  <= bus.entryIn;
              cycles_q <= '0;
              done_q   <= 1'b0;
              tout_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            entry_q <= PARK_ADDR;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort beats halt, halt beats budget exhaustion.
          if (bus.abort) begin
            state_q <= S_IDLE;
            entry_q <= PARK_ADDR;
          end else begin
            cycles_q <= cycles_sat;
            if (bus.ins == HALT_INS) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              entry_q <= PARK_ADDR;
            end else if (cycles_plus == MAX_CNT) begin
              state_q <= S_TOUT;
              tout_q  <= 1'b1;
              entry_q <= PARK_ADDR;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          entry_q <= PARK_ADDR;
        end
      endcase
    end
  end

  // INT and busy are decoded from the state register only, so they cannot glitch.
  assign bus.INT        = (state_q != S_RUN);
  assign bus.busy       = (state_q == S_ARM) || (state_q == S_RUN);
  assign bus.entryPoint = entry_q;
  assign bus.done       = done_q;
  assign bus.timeout    = tout_q;
  assign bus.startErr   = err_q;
  assign bus.cycles     = cycles_q;

endmodule
